// File: rtl/mem_controller.sv
// Byte-serial memory sequencer: splits word reads/writes into byte transfers,
// fetches opcode bytes, and returns results as one-cycle load pulses.
module mem_controller #(
  parameter int NBITS = 32,
  parameter int WORD  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_rd,
  input  logic             req_wr,
  input  logic             req_fetch,
  input  logic [NBITS-1:0] mar,
  input  logic [NBITS-1:0] pc,
  input  logic [NBITS-1:0] wdata,
  input  logic [WORD-1:0]  mem_in,
  output logic [NBITS-1:0] mem_addr,
  output logic [WORD-1:0]  mem_out,
  output logic             we,
  output logic [NBITS-1:0] mdr_data,
  output logic             mdr_load,
  output logic [WORD-1:0]  mbr_data,
  output logic             mbr_load,
  output logic             wr_done,
  output logic             busy,
  output logic             err
);
  localparam int NB = NBITS / WORD;
  localparam int CW = $clog2(NB);
  localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);

  typedef enum logic [2:0] {IDLE, RD, RD_LAST, WR, FETCH, FETCH_LAST} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic [NBITS-1:0]       base_q, base_d, pc_q, pc_d, wdat_q, wdat_d;
  logic [NBITS-WORD-1:0]  asm_q;
  logic [NBITS-1:0]       addr_d;
  logic [WORD-1:0]        out_d;
  logic                   we_d;

  logic [NBITS-1:0] mem_addr_q, mdr_data_q;
  logic [WORD-1:0]  mem_out_q, mbr_data_q;
  logic             we_q, mdr_load_q, mbr_load_q, wr_done_q, busy_q, err_q;

  // Next-state decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    base_d  = base_q;
    pc_d    = pc_q;
    wdat_d  = wdat_q;
    case (state_q)
      IDLE: begin
        if (req_rd || req_wr || req_fetch) begin
          base_d = mar << CW;
          pc_d   = pc;
          wdat_d = wdata;
        end
        if (req_rd ^ req_wr) begin
          state_d = req_rd ? RD : WR;
          cnt_d   = '0;
          pend_d  = req_fetch;
        end else if (req_fetch) begin
          state_d = FETCH;
        end
      end
      RD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = RD_LAST;
      end
      RD_LAST: state_d = pend_q ? FETCH : IDLE;
      WR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = pend_q ? FETCH : IDLE;
      end
      FETCH: state_d = FETCH_LAST;
      FETCH_LAST: begin
        pend_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs are registered from the state being entered
  always_comb begin
    addr_d = '0;
    out_d  = '0;
    we_d   = 1'b0;
    case (state_d)
      RD: addr_d = base_d + NBITS'(cnt_d);
      WR: begin
        addr_d = base_d + NBITS'(cnt_d);
        out_d  = wdat_d[cnt_d*WORD +: WORD];
        we_d   = 1'b1;
      end
      FETCH:   addr_d = pc_d;
      default: addr_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      base_q     <= '0;
      pc_q       <= '0;
      wdat_q     <= '0;
      asm_q      <= '0;
      mem_addr_q <= '0;
      mem_out_q  <= '0;
      we_q       <= 1'b0;
      mdr_data_q <= '0;
      mdr_load_q <= 1'b0;
      mbr_data_q <= '0;
      mbr_load_q <= 1'b0;
      wr_done_q  <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      base_q     <= base_d;
      pc_q       <= pc_d;
      wdat_q     <= wdat_d;
      mem_addr_q <= addr_d;
      mem_out_q  <= out_d;
      we_q       <= we_d;
      busy_q     <= (state_d != IDLE);
      mdr_load_q <= (state_q == RD_LAST);
      mbr_load_q <= (state_q == FETCH_LAST);
      wr_done_q  <= (state_q == WR) && (cnt_q == CNT_LAST);
      err_q      <= (state_q == IDLE) && req_rd && req_wr;
      // Read data lags its address by one cycle; bytes shift in low-first
      if (state_q == RD && cnt_q != '0)
        asm_q <= {mem_in, asm_q[NBITS-WORD-1:WORD]};
      if (state_q == RD_LAST)
        mdr_data_q <= {mem_in, asm_q};
      if (state_q == FETCH_LAST)
        mbr_data_q <= mem_in;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_out  = mem_out_q;
  assign we       = we_q;
  assign mdr_data = mdr_data_q;
  assign mdr_load = mdr_load_q;
  assign mbr_data = mbr_data_q;
  assign mbr_load = mbr_load_q;
  assign wr_done  = wr_done_q;
  assign busy     = busy_q;
  assign err      = err_q;
endmodule

// File: tb/tb_mem_controller.sv
// Bench for mem_controller: a schedule-based reference model predicts every
// output per cycle from the request timing rules; a ROM feeds mem_in.
module tb_mem_controller;
  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        reset, req_rd, req_wr, req_fetch;
  logic [31:0] mar, pc, wdata;
  logic [7:0]  mem_in = 8'h00;
  logic [31:0] mem_addr, mdr_data;
  logic [7:0]  mem_out, mbr_data;
  logic        we, mdr_load, mbr_load, wr_done, busy, err;

  always #5 clk = ~clk;

  mem_controller #(.NBITS(32), .WORD(8)) dut (
    .clk(clk), .reset(reset), .req_rd(req_rd), .req_wr(req_wr),
    .req_fetch(req_fetch), .mar(mar), .pc(pc), .wdata(wdata),
    .mem_in(mem_in), .mem_addr(mem_addr), .mem_out(mem_out), .we(we),
    .mdr_data(mdr_data), .mdr_load(mdr_load), .mbr_data(mbr_data),
    .mbr_load(mbr_load), .wr_done(wr_done), .busy(busy), .err(err)
  );

  function automatic logic [7:0] rom(logic [31:0] a);
    case (a)
      32'h40:  return 8'h11;
      32'h41:  return 8'h22;
      32'h42:  return 8'h33;
      32'h43:  return 8'h44;
      32'h07:  return 8'hA5;
      default: return (a[7:0] * 8'd29) ^ a[15:8] ^ a[31:24] ^ 8'h3C;
    endcase
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_in <= rom(mem_addr);

  // Expected outputs indexed by cycle
  bit [31:0] e_addr [MAXC];
  bit [7:0]  e_out  [MAXC];
  bit        e_we [MAXC], e_busy [MAXC], e_mdrl [MAXC], e_mbrl [MAXC];
  bit        e_wrd [MAXC], e_err [MAXC], e_rst [MAXC];
  bit [31:0] e_mdrv [MAXC];
  bit [7:0]  e_mbrv [MAXC];
  int        free_c = 0;

  int nchk = 0, nerr = 0;
  bit chk_en = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_fetch(int s, logic [31:0] p);
    e_addr[s+1] = p;
    e_busy[s+1] = 1'b1;
    e_busy[s+2] = 1'b1;
    e_mbrl[s+3] = 1'b1;
    e_mbrv[s+3] = rom(p);
    free_c = s + 3;
  endtask

  task automatic model_accept(int t0, bit rd, bit wr, bit fe,
                              logic [31:0] m, logic [31:0] p, logic [31:0] w);
    logic [31:0] base, word;
    base = {m[29:0], 2'b00};
    if (rd && wr) begin
      e_err[t0+1] = 1'b1;
      free_c = t0 + 1;
      if (fe) model_fetch(t0, p);
    end else if (rd) begin
      word = '0;
      for (int k = 0; k < 4; k++) begin
        e_addr[t0+1+k] = base + k;
        word = word | (32'(rom(base + k)) << (8 * k));
      end
      for (int k = 1; k <= 5; k++) e_busy[t0+k] = 1'b1;
      e_mdrl[t0+6] = 1'b1;
      e_mdrv[t0+6] = word;
      free_c = t0 + 6;
      if (fe) model_fetch(t0 + 5, p);
    end else if (wr) begin
      for (int k = 0; k < 4; k++) begin
        e_addr[t0+1+k] = base + k;
        e_we[t0+1+k]   = 1'b1;
        e_out[t0+1+k]  = w[8*k +: 8];
        e_busy[t0+1+k] = 1'b1;
      end
      e_wrd[t0+5] = 1'b1;
      free_c = t0 + 5;
      if (fe) model_fetch(t0 + 4, p);
    end else if (fe) begin
      model_fetch(t0, p);
    end
  endtask

  task automatic model_reset(int r);
    for (int t = r + 1; t < MAXC; t++) begin
      e_addr[t] = '0; e_out[t] = '0; e_we[t] = 0; e_busy[t] = 0;
      e_mdrl[t] = 0; e_mbrl[t] = 0; e_wrd[t] = 0; e_err[t] = 0;
      e_rst[t] = 0; e_mdrv[t] = '0; e_mbrv[t] = '0;
    end
    e_rst[r+1] = 1'b1;
    free_c = r + 1;
  endtask

  // Per-cycle comparison against the model
  bit [31:0] cur_mdr = '0;
  bit [7:0]  cur_mbr = '0;
  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      if (e_rst[cyc]) begin cur_mdr = '0; cur_mbr = '0; end
      if (e_mdrl[cyc]) cur_mdr = e_mdrv[cyc];
      if (e_mbrl[cyc]) cur_mbr = e_mbrv[cyc];
      chk("mem_addr", mem_addr, e_addr[cyc]);
      chk("mem_out",  32'(mem_out), 32'(e_out[cyc]));
      chk("we",       32'(we), 32'(e_we[cyc]));
      chk("busy",     32'(busy), 32'(e_busy[cyc]));
      chk("mdr_load", 32'(mdr_load), 32'(e_mdrl[cyc]));
      chk("mdr_data", mdr_data, cur_mdr);
      chk("mbr_load", 32'(mbr_load), 32'(e_mbrl[cyc]));
      chk("mbr_data", 32'(mbr_data), 32'(cur_mbr));
      chk("wr_done",  32'(wr_done), 32'(e_wrd[cyc]));
      chk("err",      32'(err), 32'(e_err[cyc]));
    end
  end

  task automatic drive(bit rst, bit rd, bit wr, bit fe,
                       logic [31:0] m, logic [31:0] p, logic [31:0] w);
    @(posedge clk);
    #1;
    reset = rst; req_rd = rd; req_wr = wr; req_fetch = fe;
    mar = m; pc = p; wdata = w;
    if (cyc < MAXC - 16) begin
      if (rst) model_reset(cyc);
      else if ((rd || wr || fe) && cyc >= free_c) model_accept(cyc, rd, wr, fe, m, p, w);
    end
  endtask

  task automatic idle_until(int t);
    while (cyc < t) drive(0, 0, 0, 0, '0, '0, '0);
  endtask

  int t0;

  initial begin
    reset = 1'b1; req_rd = 0; req_wr = 0; req_fetch = 0;
    mar = '0; pc = '0; wdata = '0;
    model_reset(0);
    drive(1, 0, 0, 0, '0, '0, '0);
    chk_en = 1'b1;
    drive(1, 0, 0, 0, '0, '0, '0);
    drive(0, 0, 0, 0, '0, '0, '0);
    @(negedge clk);
    chk("lit_rst_busy", 32'(busy), 32'd0);
    chk("lit_rst_mdr", mdr_data, 32'd0);

    // Word read
    drive(0, 1, 0, 0, 32'h10, '0, '0); t0 = cyc;
    idle_until(t0 + 1); @(negedge clk);
    chk("lit_rd_a0", mem_addr, 32'h40);
    idle_until(t0 + 6); @(negedge clk);
    chk("lit_rd_mdr", mdr_data, 32'h44332211);
    chk("lit_rd_load", 32'(mdr_load), 32'd1);

    // Word write
    drive(0, 0, 1, 0, 32'h3, '0, 32'hDEADBEEF); t0 = cyc;
    idle_until(t0 + 4); @(negedge clk);
    chk("lit_wr_a3", mem_addr, 32'hF);
    chk("lit_wr_d3", 32'(mem_out), 32'hDE);
    idle_until(t0 + 5); @(negedge clk);
    chk("lit_wr_done", 32'(wr_done), 32'd1);

    // Read plus fetch
    drive(0, 1, 0, 1, 32'h10, 32'h7, '0); t0 = cyc;
    idle_until(t0 + 6); @(negedge clk);
    chk("lit_rf_faddr", mem_addr, 32'h7);
    idle_until(t0 + 8); @(negedge clk);
    chk("lit_rf_mbr", 32'(mbr_data), 32'hA5);

    // Conflicting rd+wr with fetch
    drive(0, 1, 1, 1, 32'h20, 32'h41, 32'h12345678); t0 = cyc;
    idle_until(t0 + 1); @(negedge clk);
    chk("lit_err", 32'(err), 32'd1);
    idle_until(t0 + 3); @(negedge clk);
    chk("lit_err_mbr", 32'(mbr_data), 32'h22);

    // Wrapping read with an ignored write request mid-transfer
    drive(0, 1, 0, 0, 32'h3FFFFFFF, '0, '0); t0 = cyc;
    idle_until(t0 + 1); @(negedge clk);
    chk("lit_wrap_a0", mem_addr, 32'hFFFFFFFC);
    drive(0, 0, 1, 0, 32'h5, '0, 32'hCAFEF00D);
    idle_until(t0 + 4); @(negedge clk);
    chk("lit_wrap_a3", mem_addr, 32'hFFFFFFFF);
    idle_until(t0 + 7);

    // Reset in the middle of a write, then a clean fetch
    drive(0, 0, 1, 0, 32'h5, '0, 32'h01020304); t0 = cyc;
    idle_until(t0 + 1);
    drive(1, 0, 0, 0, '0, '0, '0);
    drive(0, 0, 0, 0, '0, '0, '0); @(negedge clk);
    chk("lit_rst_we", 32'(we), 32'd0);
    chk("lit_rst_busy2", 32'(busy), 32'd0);
    drive(0, 0, 0, 1, '0, 32'h40, '0); t0 = cyc;
    idle_until(t0 + 3); @(negedge clk);
    chk("lit_rst_fetch", 32'(mbr_data), 32'h11);

    // Randomized traffic, including requests while busy and occasional resets
    for (int i = 0; i < 1500; i++) begin
      bit rs, rd, wr, fe;
      logic [31:0] m;
      rs = ($urandom_range(0, 149) == 0);
      rd = ($urandom_range(0, 3) == 0);
      wr = ($urandom_range(0, 3) == 0);
      fe = ($urandom_range(0, 2) == 0);
      m  = ($urandom_range(0, 3) == 0) ? (32'h3FFFFFF0 | 32'($urandom_range(0, 15))) : $urandom();
      drive(rs, rd, wr, fe, m, $urandom(), $urandom());
    end
    idle_until(cyc + 12);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
